// File: rtl/fetch_queue_if.sv
// Interface bundling the imem fetch port, the decode redirect and the fetch-side
// valid/ready handshake of fetch_queue.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic [XLEN-1:0]              imem_pc;
  logic [XLEN-1:0]              imem_instr;
  logic                         redirect_valid;
  logic [XLEN-1:0]              redirect_pc;
  logic                         out_valid;
  logic                         out_ready;
  logic [XLEN-1:0]              out_pc;
  logic [XLEN-1:0]              out_instr;
  logic [$clog2(DEPTH+1)-1:0]   occupancy;

  modport master (
    output imem_pc, out_valid, out_pc, out_instr, occupancy,
    input  imem_instr, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_pc, out_valid, out_pc, out_instr, occupancy,
    output imem_instr, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: streams sequential PCs into imem and buffers {pc,instr} pairs.
// Optional FETCH_QUEUE_BYPASS_EN adds a combinational imem->out path when the queue is empty.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic        clk,
  input logic        rst_n,
  fetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  fetch_pc;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;

  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [XLEN-1:0]  instr_mem [DEPTH];

  logic             valid, pop, push, bypass, q_pop, wr_en;
  logic [XLEN-1:0]  head_pc, head_instr;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    valid      = 1'b0;
    head_pc    = '0;
    head_instr = '0;
    bypass     = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass     = !bus.redirect_valid && (count == '0);
`endif
    if (!bus.redirect_valid) begin
      if (count != '0) begin
        valid      = 1'b1;
        head_pc    = pc_mem[rd_ptr];
        head_instr = instr_mem[rd_ptr];
      end else if (bypass) begin
        valid      = 1'b1;
        head_pc    = fetch_pc;
        head_instr = bus.imem_instr;
      end
    end
    pop   = valid && bus.out_ready;
    push  = !bus.redirect_valid && ((count < CNT_W'(DEPTH)) || pop);
    // A bypassed word consumed this cycle never occupies a slot.
    q_pop = pop && !bypass;
    wr_en = push && !(bypass && pop);
  end

  assign bus.imem_pc   = fetch_pc;
  assign bus.out_valid = valid;
  assign bus.out_pc    = head_pc;
  assign bus.out_instr = head_instr;
  assign bus.occupancy = count;

  // NOTE: state registers use non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push)  fetch_pc <= fetch_pc + XLEN'(4);
      if (wr_en) wr_ptr   <= wr_ptr + PTR_W'(1);
      if (q_pop) rd_ptr   <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(wr_en) - CNT_W'(q_pop);
    end
  end

  // NOTE: entry storage is deliberately not reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= bus.imem_instr;
    end
  end
endmodule
